// File: rtl/nzp_cc_pkg.sv
// Shared types and helpers for the n/z/p condition-code unit.
// Holds the cc_t bundle, one-hot CC constants and the Data evaluator.
package nzp_cc_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_NONE = 3'b000;
  localparam cc_t CC_NEG  = 3'b100;
  localparam cc_t CC_ZERO = 3'b010;
  localparam cc_t CC_POS  = 3'b001;

  // d is zero-extended from the caller's WIDTH; w selects its sign bit.
  function automatic cc_t cc_eval(
    input logic [63:0] d,
    input int unsigned w
  );
    cc_t r;
    if (d == 64'd0)
      r = CC_ZERO;
    else if (d[w-1])
      r = CC_NEG;
    else
      r = CC_POS;
    return r;
  endfunction

endpackage

// File: rtl/nzp_cc_unit_stack.sv
// cc_stack: DEPTH-entry LIFO of saved condition codes.
// Ports: Clk, Reset, Push, Pop, Din, Dout (top entry), Level, Full, Empty.
module cc_stack
  import nzp_cc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Push,
  input  logic          Pop,
  input  cc_t           Din,
  output cc_t           Dout,
  output logic [LW-1:0] Level,
  output logic          Full,
  output logic          Empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cc_t           mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign Full    = (Level == LW'(DEPTH));
  assign Empty   = (Level == '0);
  assign do_push = Push & ~Full;
  assign do_pop  = Pop & ~Empty & ~Push;
  assign wr_idx  = AW'(Level);
  // Only meaningful when not Empty.
  assign rd_idx  = AW'(Level - LW'(1));
  assign Dout    = mem[rd_idx];

  // Entries are not cleared by Reset.
  always_ff @(posedge Clk) begin
    if (do_push && !Reset)
      mem[wr_idx] <= Din;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Level <= '0;
    else if (do_push)
      Level <= Level + LW'(1);
    else if (do_pop)
      Level <= Level - LW'(1);
  end

endmodule

// File: rtl/nzp_cc_unit.sv
// nzp_cc_unit: n/z/p condition codes, BEN and a saved-CC stack.
// Ports: Clk, Reset, Data, LD_CC, LD_BEN, IR_nzp, Push, Pop -> n, z, p, BEN, Level, Full, Empty, Ovf, Unf.
module nzp_cc_unit
  import nzp_cc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           Data,
  input  logic                       LD_CC,
  input  logic                       LD_BEN,
  input  logic [2:0]                 IR_nzp,
  input  logic                       Push,
  input  logic                       Pop,
  output logic                       n,
  output logic                       z,
  output logic                       p,
  output logic                       BEN,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Ovf,
  output logic                       Unf
);

  cc_t  cc;
  cc_t  cc_new;
  cc_t  cc_saved;
  logic push_en;
  logic pop_en;
  logic pop_only;
  logic both;

  assign both     = Push & Pop;
  assign pop_only = Pop & ~Push;
  assign push_en  = Push & ~Pop & ~Full;
  assign pop_en   = pop_only & ~Empty;
  assign cc_new   = cc_eval(64'(Data), WIDTH);

  cc_stack #(
    .DEPTH(DEPTH)
  ) u_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .Push  (push_en),
    .Pop   (pop_en),
    .Din   (cc),
    .Dout  (cc_saved),
    .Level (Level),
    .Full  (Full),
    .Empty (Empty)
  );

  // A lone Pop owns the CC even when it fails on empty.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      cc <= CC_NONE;
    else if (pop_only) begin
      if (!Empty)
        cc <= cc_saved;
    end else if (LD_CC)
      cc <= cc_new;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      BEN <= 1'b0;
    else if (LD_BEN)
      BEN <= |(IR_nzp & cc);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Ovf <= 1'b0;
      Unf <= 1'b0;
    end else begin
      if (Push && (Full || both))
        Ovf <= 1'b1;
      if (Pop && (Empty || both))
        Unf <= 1'b1;
    end
  end

  assign n = cc.n;
  assign z = cc.z;
  assign p = cc.p;

endmodule
